// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out a refund balance coin by coin through a valid/ack coin hopper.
//   Denominations are chosen greedily (largest first); tubes flagged empty
//   are skipped. Reports completion, coin count and any unpaid shortfall.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   refund_req   one-cycle request strobe (ignored while busy)
//   refund_amt   amount to refund, sampled with refund_req
//   coin_empty   per-denomination tube-empty flags, sampled only in SELECT
//   coin_ack     hopper ejected the presented coin (honoured only in ISSUE)
//   coin_valid   coin request presented to the hopper
//   coin_sel     one-hot denomination select, meaningful while coin_valid=1
//   busy         refund in progress
//   done         one-cycle completion pulse
//   fault        last refund ended with value still owed
//   shortfall    value still owed at the end of the last refund
//   coin_count   coins dispensed in the current/last refund (saturates at 31)
//   dbg_state_o  current FSM state, for observation only
//
// Hopper handshake: coin_valid rises with coin_sel already stable and both
// hold unchanged until the cycle coin_ack=1 is sampled at a rising edge;
// coin_valid drops on the following cycle. coin_ack outside ISSUE has no
// effect.
module change_dispenser #(
  parameter int COIN3      = 20,
  parameter int COIN2      = 10,
  parameter int COIN1      = 5,
  parameter int COIN0      = 1,
  parameter int MAX_AMT    = 99,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refund_req,
  input  logic [6:0] refund_amt,
  input  logic [3:0] coin_empty,
  input  logic       coin_ack,
  output logic       coin_valid,
  output logic [3:0] coin_sel,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [6:0] shortfall,
  output logic [4:0] coin_count,
  output logic [2:0] dbg_state_o
);

  localparam logic [6:0] C3      = 7'(COIN3);
  localparam logic [6:0] C2      = 7'(COIN2);
  localparam logic [6:0] C1      = 7'(COIN1);
  localparam logic [6:0] C0      = 7'(COIN0);
  localparam logic [6:0] MAX_C   = 7'(MAX_AMT);
  localparam logic [3:0] GAP_RLD = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_ISSUE  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] rem_q, rem_d;
  logic [3:0] gap_q, gap_d;
  logic       valid_q, valid_d;
  logic [3:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       fault_q, fault_d;
  logic [6:0] short_q, short_d;
  logic [4:0] count_q, count_d;

  // Greedy pick: later (larger) denominations override smaller ones.
  logic       pick_found;
  logic [3:0] pick_sel;
  always_comb begin
    pick_found = 1'b0;
    pick_sel   = 4'b0000;
    if (!coin_empty[0] && C0 <= rem_q) begin pick_found = 1'b1; pick_sel = 4'b0001; end
    if (!coin_empty[1] && C1 <= rem_q) begin pick_found = 1'b1; pick_sel = 4'b0010; end
    if (!coin_empty[2] && C2 <= rem_q) begin pick_found = 1'b1; pick_sel = 4'b0100; end
    if (!coin_empty[3] && C3 <= rem_q) begin pick_found = 1'b1; pick_sel = 4'b1000; end
  end

  // Value of the coin currently presented; sel_q is one-hot in ISSUE.
  logic [6:0] issue_val;
  always_comb begin
    issue_val = 7'd0;
    case (sel_q)
      4'b0001: issue_val = C0;
      4'b0010: issue_val = C1;
      4'b0100: issue_val = C2;
      4'b1000: issue_val = C3;
      default: issue_val = 7'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fault_d = fault_q;
    short_d = short_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (refund_req) begin
          // Clip before any truncation so oversize requests pay MAX_AMT.
          rem_d   = (refund_amt > MAX_C) ? MAX_C : refund_amt;
          fault_d = 1'b0;
          short_d = 7'd0;
          count_d = 5'd0;
          busy_d  = 1'b1;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (rem_q == 7'd0) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (pick_found) begin
          sel_d   = pick_sel;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end else begin
          done_d  = 1'b1;
          fault_d = 1'b1;
          short_d = rem_q;
          state_d = S_DONE;
        end
      end
      S_ISSUE: begin
        if (coin_ack) begin
          // Selection guaranteed issue_val <= rem_q, so no underflow.
          rem_d   = rem_q - issue_val;
          count_d = (count_q == 5'd31) ? count_q : count_q + 5'd1;
          valid_d = 1'b0;
          sel_d   = 4'b0000;
          gap_d   = GAP_RLD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = S_SELECT;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rem_q   <= 7'd0;
      gap_q   <= 4'd0;
      valid_q <= 1'b0;
      sel_q   <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      short_q <= 7'd0;
      count_q <= 5'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      short_q <= short_d;
      count_q <= count_d;
    end
  end

  assign coin_valid  = valid_q;
  assign coin_sel    = sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign shortfall   = short_q;
  assign coin_count  = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int GAP = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       refund_req;
  logic [6:0] refund_amt;
  logic [3:0] coin_empty;
  logic       coin_ack;
  logic       coin_valid;
  logic [3:0] coin_sel;
  logic       busy;
  logic       done;
  logic       fault;
  logic [6:0] shortfall;
  logic [4:0] coin_count;
  logic [2:0] dbg_state_o;

  always #5 clk = ~clk;

  change_dispenser #(
    .COIN3(20), .COIN2(10), .COIN1(5), .COIN0(1),
    .MAX_AMT(99), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .refund_req(refund_req), .refund_amt(refund_amt),
    .coin_empty(coin_empty), .coin_ack(coin_ack),
    .coin_valid(coin_valid), .coin_sel(coin_sel),
    .busy(busy), .done(done), .fault(fault),
    .shortfall(shortfall), .coin_count(coin_count),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  int exp_cnt;
  int exp_flt;
  int exp_sh;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference model: greedy change-making over the coin values with
  // empty tubes removed; fills the expected coin queue and totals.
  task automatic model(input int amt, input logic [3:0] empty);
    int vals[4];
    int rem;
    int n;
    bit found;
    vals = '{1, 5, 10, 20};
    rem = (amt > 99) ? 99 : amt;
    n = 0;
    exp_q.delete();
    while (rem > 0) begin
      found = 0;
      for (int k = 3; k >= 0; k--) begin
        if (!found && !empty[k] && vals[k] <= rem) begin
          found = 1;
          rem -= vals[k];
          exp_q.push_back(4'(1 << k));
          n++;
        end
      end
      if (!found) break;
    end
    exp_cnt = (n > 31) ? 31 : n;
    exp_flt = (rem != 0) ? 1 : 0;
    exp_sh  = rem;
  endtask

  // ---------------- driver ----------------
  // Issues one refund and plays hopper; checks every coin, the request-to-
  // first-event latency (2), the ack-to-next-event latency (2+GAP), coin
  // stability while ack is withheld, and the final totals. With poke set,
  // a stray refund_req (amount 50) and a stray coin_ack are thrown in.
  task automatic do_refund(input logic [6:0] amt, input logic [3:0] empty,
                           input int dmin, input int dmax, input bit poke);
    int lat;
    int exp_lat;
    int d;
    bit fin;
    logic [3:0] sel;
    @(negedge clk);
    refund_req = 1'b1;
    refund_amt = amt;
    coin_empty = empty;
    @(negedge clk);
    refund_req = 1'b0;
    refund_amt = 7'($urandom_range(0, 127));
    chk("busy_after_req", int'(busy), 1);
    lat = 1;
    exp_lat = 2;
    fin = 0;
    while (!fin) begin
      coin_ack = poke && (lat == 1);
      while (!coin_valid && !done && lat < exp_lat + 40) begin
        @(negedge clk);
        lat++;
        coin_ack = 1'b0;
      end
      coin_ack = 1'b0;
      if (!coin_valid && !done) begin
        chk("event_timeout", lat, exp_lat);
        return;
      end
      chk("event_latency", lat, exp_lat);
      if (coin_valid) begin
        chk("coin_sel", int'(coin_sel), exp_q.size() > 0 ? int'(exp_q.pop_front()) : 0);
        sel = coin_sel;
        d = $urandom_range(dmin, dmax);
        if (poke) begin
          refund_req = 1'b1;
          refund_amt = 7'd50;
        end
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          refund_req = 1'b0;
          chk("valid_hold", int'(coin_valid), 1);
          chk("sel_hold", int'(coin_sel), int'(sel));
        end
        refund_req = 1'b0;
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        chk("valid_drop", int'(coin_valid), 0);
        lat = 1;
        exp_lat = GAP + 2;
      end else begin
        fin = 1;
        chk("coins_left", exp_q.size(), 0);
        chk("count", int'(coin_count), exp_cnt);
        chk("fault", int'(fault), exp_flt);
        chk("shortfall", int'(shortfall), exp_sh);
        chk("busy_in_done", int'(busy), 1);
        @(negedge clk);
        chk("done_width", int'(done), 0);
        chk("busy_after_done", int'(busy), 0);
        chk("count_hold", int'(coin_count), exp_cnt);
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [6:0]  amt;
    logic [3:0]  empty;
    logic [47:0] seq;   // coin_sel sequence, first coin in the low nibble
    int          n;
    int          cnt;
    int          flt;
    int          sh;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{7'd37,  4'b0000, 48'h11248,      5,  5,  0, 0};
    tbl[1] = '{7'd0,   4'b0000, 48'h0,          0,  0,  0, 0};
    tbl[2] = '{7'd120, 4'b0000, 48'h1111248888, 10, 10, 0, 0};
    tbl[3] = '{7'd37,  4'b1000, 48'h112444,     6,  6,  0, 0};
    tbl[4] = '{7'd8,   4'b0001, 48'h2,          1,  1,  1, 3};
    tbl[5] = '{7'd6,   4'b0000, 48'h12,         2,  2,  0, 0};

    rst = 1'b0;
    refund_req = 1'b0;
    refund_amt = 7'd0;
    coin_empty = 4'd0;
    coin_ack = 1'b0;
    #1;
    chk("reset_outputs", int'({coin_valid, coin_sel, busy, done, fault, shortfall, coin_count}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // table-driven vectors, immediate acks
    for (int v = 0; v < 6; v++) begin
      exp_q.delete();
      for (int k = 0; k < tbl[v].n; k++) exp_q.push_back(tbl[v].seq[4*k +: 4]);
      exp_cnt = tbl[v].cnt;
      exp_flt = tbl[v].flt;
      exp_sh  = tbl[v].sh;
      do_refund(tbl[v].amt, tbl[v].empty, 0, 0, 1'b0);
    end

    // ack withheld 7 cycles, stray request and stray ack thrown in
    model(37, 4'b0000);
    do_refund(7'd37, 4'b0000, 7, 7, 1'b1);

    // reset in the middle of ISSUE
    @(negedge clk);
    refund_req = 1'b1;
    refund_amt = 7'd37;
    coin_empty = 4'b0000;
    @(negedge clk);
    refund_req = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", int'(coin_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outputs", int'({coin_valid, coin_sel, busy, done, fault, shortfall, coin_count}), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", int'({coin_valid, busy, done}), 0);
    exp_q.delete();
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    exp_cnt = 2;
    exp_flt = 0;
    exp_sh  = 0;
    do_refund(7'd6, 4'b0000, 0, 0, 1'b0);

    // randomized refunds against the reference model
    for (int r = 0; r < 30; r++) begin
      logic [6:0] a;
      logic [3:0] e;
      a = 7'($urandom_range(0, 127));
      e = 4'($urandom_range(0, 15));
      model(int'(a), e);
      do_refund(a, e, 0, 3, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
